// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous-read frame-buffer RAM
// between VGA scan-out (prefetched two pixels ahead) and a CPU requester.
// Optional build macro: VGA_FB_VBLANK_ONLY_EN restricts CPU slots to vblank.
module vga_fb_arbiter #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned SCALE     = 2,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              bright,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned FB_W     = H_VISIBLE >> SCALE;
  localparam logic [CNT_W-1:0] SUB_MASK = CNT_W'((1 << SCALE) - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic              cpu_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              disp_q;
  logic [DATA_W-1:0] pix_q;

  logic [CNT_W:0]    h_plus2_c;
  logic [CNT_W-1:0]  hn_c;
  logic [CNT_W-1:0]  rn_c;
  logic              disp_slot_c;
  logic              free_slot_c;
  logic              cpu_issue_c;
  logic [ADDR_W-1:0] disp_addr_c;

  // Lookahead position two pixel clocks ahead, wrapping line and frame
  always_comb begin
    h_plus2_c = (CNT_W+1)'(hcount) + (CNT_W+1)'(2);
    hn_c      = CNT_W'(h_plus2_c);
    rn_c      = vcount;
    if (h_plus2_c >= (CNT_W+1)'(H_TOTAL)) begin
      hn_c = CNT_W'(h_plus2_c - (CNT_W+1)'(H_TOTAL));
      rn_c = (vcount >= CNT_W'(V_TOTAL - 1)) ? '0 : vcount + CNT_W'(1);
    end
  end

  // Display fetch slot: first replicated pixel of each frame-buffer word
  always_comb begin
    disp_slot_c = (hn_c < CNT_W'(H_VISIBLE)) && (rn_c < CNT_W'(V_VISIBLE)) &&
                  ((hn_c & SUB_MASK) == '0);
    disp_addr_c = ADDR_W'(((32'(rn_c) >> SCALE) * FB_W) + (32'(hn_c) >> SCALE));
  end

  // CPU may use the RAM only in cycles the display does not claim
  always_comb begin
`ifdef VGA_FB_VBLANK_ONLY_EN
    free_slot_c = !disp_slot_c && (vcount >= CNT_W'(V_VISIBLE));
`else
    free_slot_c = !disp_slot_c;
`endif
    cpu_issue_c = (state_q == ST_IDLE) && cpu_req && free_slot_c;
  end

  // RAM port mux; CPU values rest on the bus when nobody issues
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (disp_slot_c) begin
      mem_addr = disp_addr_c;
    end else if (cpu_issue_c) begin
      mem_we = cpu_we;
    end
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // CPU handshake FSM: issue, capture read data, one-cycle ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_issue_c) begin
            we_q    <= cpu_we;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!we_q) begin
            cpu_rdata_q <= mem_rdata;
          end
          cpu_ack_q <= 1'b1;
          state_q   <= ST_ACK;
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Pixel register loads the word returned one cycle after a display fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= 1'b0;
      pix_q  <= '0;
    end else begin
      disp_q <= disp_slot_c;
      if (disp_q) begin
        pix_q <= mem_rdata;
      end
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign pix_data  = bright ? pix_q : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: SCALE=2 and SCALE=0 instances, behavioural RAMs,
// bench-driven (jumpable) raster counters, queue-based expectations.
module tb_vga_fb_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    hcount, vcount;
  logic          bright;

  // SCALE = 2 instance
  logic          a_req, a_we, a_ack, a_mwe;
  logic [AW-1:0] a_addr, a_maddr;
  logic [DW-1:0] a_wdata, a_rdata, a_mwdata, a_mrdata, a_pix;
  // SCALE = 0 instance
  logic          b_req, b_we, b_ack, b_mwe;
  logic [AW-1:0] b_addr, b_maddr;
  logic [DW-1:0] b_wdata, b_rdata, b_mwdata, b_mrdata, b_pix;

  // Backdoor preload port for RAM A
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic [DW-1:0] ram_a [0:(1<<AW)-1];
  logic [DW-1:0] ram_b [0:(1<<AW)-1];

  int            errors = 0;
  int            checks = 0;
  int            sb_q[$];

  always #5 clk = ~clk;

  vga_fb_arbiter #(.SCALE(2)) u_dut_a (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .bright(bright),
    .cpu_req(a_req), .cpu_we(a_we), .cpu_addr(a_addr), .cpu_wdata(a_wdata),
    .cpu_ack(a_ack), .cpu_rdata(a_rdata), .mem_addr(a_maddr), .mem_we(a_mwe),
    .mem_wdata(a_mwdata), .mem_rdata(a_mrdata), .pix_data(a_pix)
  );

  vga_fb_arbiter #(.SCALE(0)) u_dut_b (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .bright(bright),
    .cpu_req(b_req), .cpu_we(b_we), .cpu_addr(b_addr), .cpu_wdata(b_wdata),
    .cpu_ack(b_ack), .cpu_rdata(b_rdata), .mem_addr(b_maddr), .mem_we(b_mwe),
    .mem_wdata(b_mwdata), .mem_rdata(b_mrdata), .pix_data(b_pix)
  );

  // Single-port synchronous-read RAMs
  always_ff @(posedge clk) begin
    if (bd_we) ram_a[bd_addr] <= bd_data;
    else if (a_mwe) ram_a[a_maddr] <= a_mwdata;
    a_mrdata <= ram_a[a_maddr];
  end

  always_ff @(posedge clk) begin
    if (b_mwe) ram_b[b_maddr] <= b_mwdata;
    b_mrdata <= ram_b[b_maddr];
  end

  task automatic set_bright();
    bright = (hcount < 10'd640) && (vcount < 10'd480);
  endtask

  // Advance one pixel clock; returns with inputs applied and settled
  task automatic step();
    @(posedge clk);
    #1;
    if (hcount == 10'd799) begin
      hcount = 10'd0;
      vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount = hcount + 10'd1;
    end
    set_bright();
    #1;
  endtask

  task automatic jump(input logic [9:0] v, input logic [9:0] h);
    vcount = v;
    hcount = h;
    set_bright();
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bd_we   = 1'b1;
    bd_addr = addr;
    bd_data = data;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (v=%0d h=%0d)", nm, act, exp, vcount, hcount);
    end
  endtask

  task automatic pop_cmp(input string nm, input int act);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0h", nm, act);
    end else begin
      cmp(nm, act, sb_q.pop_front());
    end
  endtask

  // Step until a_ack or budget expires; returns with ok flag
  task automatic wait_ack_a(input string nm, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (a_ack) ok = 1'b1;
      else step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no cpu_ack within %0d cycles", nm, budget);
    end
  endtask

  task automatic test_reset();
    sb_q.delete();
    reset = 1'b0;
    jump(10'd200, 10'd300);
    for (int i = 0; i < 3; i++) step();
    // Mid-frame reset with a write held in a free slot
    reset  = 1'b1;
    a_req  = 1'b1;
    a_we   = 1'b1;
    a_addr = 15'd200;
    a_wdata = 16'hDEAD;
    #1;
    cmp("reset_ack", int'(a_ack), 0);
    cmp("reset_pix", int'(a_pix), 0);
    cmp("reset_mem_we", int'(a_mwe), 0);
    step();
    cmp("reset_mem_we_held", int'(a_mwe), 0);
    a_req = 1'b0;
    reset = 1'b0;
    // First pixels of the next frame
    jump(10'd524, 10'd790);
    for (int i = 0; i < 10; i++) step();
    for (int k = 0; k < 4; k++) sb_q.push_back(32'h0000A5A5);
    sb_q.push_back(32'h00001111);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      pop_cmp("reset_first_pix", int'(a_pix));
    end
    cmp("reset_pix_pos", int'({vcount, hcount}), 4);
  endtask

  task automatic test_scanout(input logic [9:0] vprev, input int base);
    sb_q.delete();
    jump(vprev, 10'd790);
    for (int k = 0; k < 160; k++) sb_q.push_back(base + k);
    for (int i = 0; i < 8; i++) step();
    pop_cmp("scan_first_addr", int'(a_maddr));
    cmp("scan_first_we", int'(a_mwe), 0);
    for (int i = 0; i < 800; i++) begin
      step();
      if (hcount[1:0] == 2'd2 && hcount <= 10'd634) pop_cmp("scan_addr", int'(a_maddr));
    end
    cmp("scan_all_fetched", sb_q.size(), 0);
  endtask

  task automatic test_cpu_write();
    logic got_iss, got_ack;
    logic [9:0] vline;
`ifdef VGA_FB_VBLANK_ONLY_EN
    vline = 10'd490;
    sb_q.push_back(10);
    sb_q.push_back(12);
`else
    vline = 10'd20;
    sb_q.push_back(11);
    sb_q.push_back(13);
`endif
    jump(vline, 10'd10);
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'd5; a_wdata = 16'h1234;
    #1;
    got_iss = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 12 && !got_ack; i++) begin
      if (a_mwe && !got_iss) begin
        got_iss = 1'b1;
        pop_cmp("wr_issue_h", int'(hcount));
        cmp("wr_issue_addr", int'(a_maddr), 5);
        cmp("wr_issue_data", int'(a_mwdata), 32'h1234);
      end
      if (a_ack) begin
        got_ack = 1'b1;
        pop_cmp("wr_ack_h", int'(hcount));
        a_req = 1'b0;
      end
      if (!got_ack) step();
    end
    if (!got_ack) begin
      checks++;
      errors++;
      $display("FAIL wr_ack: no cpu_ack (issued=%0d)", got_iss);
      a_req = 1'b0;
    end
    // Next frame: word 5 covers columns 20..23 of line 0
    sb_q.delete();
    sb_q.push_back(32'h4444);
    for (int k = 0; k < 4; k++) sb_q.push_back(32'h1234);
    sb_q.push_back(32'h6666);
    jump(10'd524, 10'd790);
    for (int i = 0; i < 29; i++) step();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      pop_cmp("wr_frame_pix", int'(a_pix));
    end
  endtask

  task automatic test_cpu_read();
    logic ok;
    sb_q.delete();
    jump(10'd500, 10'd700);
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'd100; a_wdata = 16'h0;
    sb_q.push_back(702);
    sb_q.push_back(32'hBEEF);
    #1;
    cmp("rd_issue_addr", int'(a_maddr), 100);
    cmp("rd_issue_we", int'(a_mwe), 0);
    wait_ack_a("rd_ack", 10, ok);
    if (ok) begin
      pop_cmp("rd_ack_h", int'(hcount));
      pop_cmp("rd_data", int'(a_rdata));
    end
    a_addr = 15'd0;
    sb_q.delete();
    sb_q.push_back(int'(hcount) + 3);
    sb_q.push_back(32'hA5A5);
    step();
    cmp("b2b_no_ack", int'(a_ack), 0);
    wait_ack_a("b2b_ack", 10, ok);
    if (ok) begin
      pop_cmp("b2b_ack_h", int'(hcount));
      pop_cmp("b2b_data", int'(a_rdata));
    end
    a_req = 1'b0;
    step();
    cmp("b2b_ack_one_cycle", int'(a_ack), 0);
  endtask

  task automatic test_scale0();
    logic got_iss, got_ack;
    sb_q.delete();
`ifdef VGA_FB_VBLANK_ONLY_EN
    jump(10'd478, 10'd0);
    sb_q.push_back((480 << 10) | 0);
    sb_q.push_back((480 << 10) | 2);
`else
    jump(10'd10, 10'd0);
    sb_q.push_back((10 << 10) | 638);
    sb_q.push_back((10 << 10) | 640);
`endif
    b_req = 1'b1; b_we = 1'b1; b_addr = 15'd3; b_wdata = 16'h0BAD;
    #1;
    got_iss = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 2100 && !got_ack; i++) begin
      if (b_mwe && !got_iss) begin
        got_iss = 1'b1;
        pop_cmp("s0_issue_pos", int'({vcount, hcount}));
      end
      if (b_ack) begin
        got_ack = 1'b1;
        pop_cmp("s0_ack_pos", int'({vcount, hcount}));
        b_req = 1'b0;
      end
      if (!got_ack) step();
    end
    if (!got_ack) begin
      checks++;
      errors++;
      $display("FAIL s0_ack: no cpu_ack (issued=%0d)", got_iss);
      b_req = 1'b0;
    end
  endtask

  task automatic test_reset_in_wait();
    logic ok;
    sb_q.delete();
    jump(10'd500, 10'd100);
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'd100;
    step();
    // Now in WAIT: pulse reset inside the cycle
    reset = 1'b1;
    #1;
    reset = 1'b0;
    a_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("rst_wait_no_ack", int'(a_ack), 0);
    end
    // Re-present: must issue at once (IDLE) and ack two cycles later
    a_req = 1'b1;
    sb_q.push_back(int'(hcount) + 2);
    sb_q.push_back(32'hBEEF);
    #1;
    cmp("rst_wait_reissue_addr", int'(a_maddr), 100);
    wait_ack_a("rst_wait_ack", 10, ok);
    if (ok) begin
      pop_cmp("rst_wait_ack_h", int'(hcount));
      pop_cmp("rst_wait_data", int'(a_rdata));
    end
    a_req = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    hcount = 10'd0; vcount = 10'd0; bright = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    preload(15'd0,   16'hA5A5);
    preload(15'd1,   16'h1111);
    preload(15'd4,   16'h4444);
    preload(15'd5,   16'h5555);
    preload(15'd6,   16'h6666);
    preload(15'd100, 16'hBEEF);
    test_reset();
    test_scanout(10'd524, 0);
    test_scanout(10'd3, 160);
    test_cpu_write();
    test_cpu_read();
    test_scale0();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
